// File: rtl/vga_pixel_out.sv
// VGA pixel output stage for the 128x128 monochrome bitmap path: aligns syncs and
// window to the ROM read pipeline, selects the pixel bit, applies blinking and registers the pins.
module vga_pixel_out #(
  parameter int unsigned ROM_LAT      = 1,
  parameter logic [2:0]  FG_COLOR     = 3'b010,
  parameter logic [2:0]  BG_COLOR     = 3'b000,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_window,
  input  logic [2:0] index,
  input  logic [7:0] rom_data,
  input  logic       blink_en,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic [2:0] out_rgb,
  output logic       frame_tick
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned RGB_W    = 3;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SYNC_LEN = ROM_LAT + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [ROM_LAT-1:0][IDX_W-1:0] idx_pipe_q, idx_pipe_d;
  logic [SYNC_LEN-1:0]           hs_pipe_q, hs_pipe_d;
  logic [SYNC_LEN-1:0]           vs_pipe_q, vs_pipe_d;
  logic [SYNC_LEN-1:0]           win_pipe_q, win_pipe_d;

  logic             out_hsync_q, out_hsync_d;
  logic             out_vsync_q, out_vsync_d;
  logic [RGB_W-1:0] out_rgb_q, out_rgb_d;
  logic             frame_tick_q, frame_tick_d;
  logic             vsync_prev_q, vsync_prev_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic [IDX_W-1:0] idx_al_c;
  logic             win_al_c;
  logic             pix_c;
  logic             frame_edge_c;

  // Delay lines: index by ROM_LAT, syncs/window by ROM_LAT+1, all landing with rom_data.
  always_comb begin
    idx_pipe_d    = '0;
    idx_pipe_d[0] = index;
    for (int i = 1; i < int'(ROM_LAT); i++) begin
      idx_pipe_d[i] = idx_pipe_q[i-1];
    end
    hs_pipe_d  = {hs_pipe_q[SYNC_LEN-2:0], in_hsync};
    vs_pipe_d  = {vs_pipe_q[SYNC_LEN-2:0], in_vsync};
    win_pipe_d = {win_pipe_q[SYNC_LEN-2:0], in_window};
  end

  // Pixel select and colour; bit 7 of the byte is the leftmost pixel.
  always_comb begin
    idx_al_c    = idx_pipe_q[ROM_LAT-1];
    win_al_c    = win_pipe_q[SYNC_LEN-1];
    pix_c       = rom_data[IDX_W'(3'd7 - idx_al_c)];
    out_hsync_d = hs_pipe_q[SYNC_LEN-1];
    out_vsync_d = vs_pipe_q[SYNC_LEN-1];
    out_rgb_d   = BG_COLOR;
    if (!win_al_c) begin
      out_rgb_d = '0;
    end else if (pix_c && !(blink_en && blink_phase_q)) begin
      out_rgb_d = FG_COLOR;
    end
  end

  // Frame edge on the raw vsync, blink counter wraps and toggles the phase.
  always_comb begin
    frame_edge_c  = vsync_prev_q && !in_vsync;
    vsync_prev_d  = in_vsync;
    frame_tick_d  = frame_edge_c;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_edge_c) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_pipe_q    <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      win_pipe_q    <= '0;
      out_hsync_q   <= 1'b1;
      out_vsync_q   <= 1'b1;
      out_rgb_q     <= '0;
      frame_tick_q  <= 1'b0;
      vsync_prev_q  <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      idx_pipe_q    <= idx_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      win_pipe_q    <= win_pipe_d;
      out_hsync_q   <= out_hsync_d;
      out_vsync_q   <= out_vsync_d;
      out_rgb_q     <= out_rgb_d;
      frame_tick_q  <= frame_tick_d;
      vsync_prev_q  <= vsync_prev_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign out_hsync  = out_hsync_q;
  assign out_vsync  = out_vsync_q;
  assign out_rgb    = out_rgb_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out: four instances (default, BG=001, BLINK_FRAMES=2, ROM_LAT=3)
// share stimulus; expected values are hand-derived cycle positions.
module tb_vga_pixel_out;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_hsync, in_vsync, in_window, blink_en;
  logic [2:0] index;
  logic [7:0] rom_data;

  logic       hs_a, vs_a, tk_a;
  logic [2:0] rgb_a;
  logic       hs_b, vs_b, tk_b;
  logic [2:0] rgb_b;
  logic       hs_c, vs_c, tk_c;
  logic [2:0] rgb_c;
  logic       hs_d, vs_d, tk_d;
  logic [2:0] rgb_d;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vga_pixel_out dut (
    .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_window(in_window),
    .index(index), .rom_data(rom_data), .blink_en(blink_en),
    .out_hsync(hs_a), .out_vsync(vs_a), .out_rgb(rgb_a), .frame_tick(tk_a));

  vga_pixel_out #(.BG_COLOR(3'b001)) dut_bg (
    .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_window(in_window),
    .index(index), .rom_data(rom_data), .blink_en(blink_en),
    .out_hsync(hs_b), .out_vsync(vs_b), .out_rgb(rgb_b), .frame_tick(tk_b));

  vga_pixel_out #(.BLINK_FRAMES(2)) dut_blk (
    .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_window(in_window),
    .index(index), .rom_data(rom_data), .blink_en(blink_en),
    .out_hsync(hs_c), .out_vsync(vs_c), .out_rgb(rgb_c), .frame_tick(tk_c));

  vga_pixel_out #(.ROM_LAT(3)) dut_l3 (
    .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync), .in_window(in_window),
    .index(index), .rom_data(rom_data), .blink_en(blink_en),
    .out_hsync(hs_d), .out_vsync(vs_d), .out_rgb(rgb_d), .frame_tick(tk_d));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_hsync  = 1'b1;
    in_vsync  = 1'b1;
    in_window = 1'b0;
    index     = 3'd0;
    blink_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rom_data = 8'hFF;
    do_reset();
    tests_run++;
    if ({hs_a, vs_a, rgb_a, tk_a} !== 6'b110000) begin
      tests_failed++;
      $display("FAIL reset_state got %b exp 110000", {hs_a, vs_a, rgb_a, tk_a});
    end
    for (int c = 0; c < 6; c++) step();
  endtask

  // Single-cycle pulses at c=10: ROM_LAT=1 shows them at c=13, ROM_LAT=3 at c=15.
  task automatic test_latency();
    rom_data = 8'hFF;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < 20; c++) begin
        in_hsync  = !(s == 0 && c == 10);
        in_vsync  = !(s == 1 && c == 10);
        in_window = (s == 2 && c == 10);
        if (s == 0) begin
          tests_run++;
          if (hs_a !== (c != 13) || hs_d !== (c != 15)) begin
            tests_failed++;
            $display("FAIL lat_hsync c=%0d got %b/%b exp %b/%b", c, hs_a, hs_d, c != 13, c != 15);
          end
        end else if (s == 1) begin
          tests_run++;
          if (vs_a !== (c != 13) || vs_d !== (c != 15)) begin
            tests_failed++;
            $display("FAIL lat_vsync c=%0d got %b/%b exp %b/%b", c, vs_a, vs_d, c != 13, c != 15);
          end
        end else begin
          tests_run++;
          if (rgb_a !== ((c == 13) ? 3'b010 : 3'b000) || rgb_d !== ((c == 15) ? 3'b010 : 3'b000)) begin
            tests_failed++;
            $display("FAIL lat_window c=%0d got %b/%b", c, rgb_a, rgb_d);
          end
        end
        step();
      end
    end
    idle_inputs();
  endtask

  // Window opens at n=0 for 8 pixels; index k arrives at n=k+1.
  task automatic test_bit_order(input logic [7:0] pattern, input logic [2:0] exp_a [8],
                                input logic [2:0] exp_d [8], input string name);
    rom_data = pattern;
    for (int c = 0; c < 8; c++) step();
    for (int n = 0; n < 15; n++) begin
      in_window = (n < 8);
      index     = (n >= 1 && n <= 8) ? 3'(n - 1) : 3'd0;
      step();
      // now in cycle n+1: ROM_LAT=1 shows pixel n-2, ROM_LAT=3 shows pixel n-4
      tests_run++;
      if (rgb_a !== ((n >= 2 && n <= 9) ? exp_a[n-2] : 3'b000)) begin
        tests_failed++;
        $display("FAIL %s_lat1 n=%0d got %b", name, n, rgb_a);
      end
      tests_run++;
      if (rgb_d !== ((n >= 4 && n <= 11) ? exp_d[n-4] : 3'b000)) begin
        tests_failed++;
        $display("FAIL %s_lat3 n=%0d got %b", name, n, rgb_d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_window_blank();
    rom_data  = 8'hFF;
    in_window = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if (rgb_a !== 3'b000 || rgb_b !== 3'b000) begin
        tests_failed++;
        $display("FAIL window_blank c=%0d got %b/%b exp 000", c, rgb_a, rgb_b);
      end
    end
    rom_data  = 8'h00;
    in_window = 1'b1;
    for (int c = 0; c < 4; c++) step();
    tests_run++;
    if (rgb_b !== 3'b001 || rgb_a !== 3'b000) begin
      tests_failed++;
      $display("FAIL bg_inside got %b/%b exp 001/000", rgb_b, rgb_a);
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) step();
  endtask

  // Edges at c=5,15,25,35; phase toggles on edges 2 and 4, seen on pins at c=17 and c=37.
  task automatic test_blink(input logic en);
    idle_inputs();
    rom_data  = 8'hFF;
    in_window = 1'b1;
    blink_en  = en;
    do_reset();
    for (int c = 0; c < 45; c++) begin
      in_vsync = !(c < 40 && (c % 10 == 5 || c % 10 == 6));
      tests_run++;
      if (tk_c !== (c == 6 || c == 16 || c == 26 || c == 36)) begin
        tests_failed++;
        $display("FAIL blink_tick en=%0b c=%0d got %b", en, c, tk_c);
      end
      if (c >= 3) begin
        tests_run++;
        if (rgb_c !== ((en && c >= 17 && c < 37) ? 3'b000 : 3'b010)) begin
          tests_failed++;
          $display("FAIL blink_rgb en=%0b c=%0d got %b", en, c, rgb_c);
        end
        tests_run++;
        if (rgb_a !== 3'b010) begin
          tests_failed++;
          $display("FAIL blink_default en=%0b c=%0d got %b exp 010", en, c, rgb_a);
        end
      end
      step();
    end
    idle_inputs();
  endtask

  // Reset mid-line with active pixels and low syncs; in_vsync held low across release.
  task automatic test_reset_midframe();
    rom_data  = 8'hFF;
    in_window = 1'b1;
    in_hsync  = 1'b0;
    in_vsync  = 1'b0;
    for (int c = 0; c < 6; c++) step();
    tests_run++;
    if ({hs_a, vs_a, rgb_a} !== 5'b00010) begin
      tests_failed++;
      $display("FAIL pre_reset got %b exp 00010", {hs_a, vs_a, rgb_a});
    end
    do_reset();
    for (int c = 0; c < 6; c++) begin
      tests_run++;
      if (tk_a !== 1'b0 || tk_c !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_no_tick c=%0d got %b/%b exp 0", c, tk_a, tk_c);
      end
      tests_run++;
      if ({hs_a, vs_a, rgb_a} !== ((c >= 3) ? 5'b00010 : 5'b11000)) begin
        tests_failed++;
        $display("FAIL reset_refill c=%0d got %b", c, {hs_a, vs_a, rgb_a});
      end
      step();
    end
    idle_inputs();
  endtask

  logic [2:0] exp81_a [8] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
  logic [2:0] expa5   [8] = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b010};

  initial begin
    rst = 1'b1;
    rom_data = 8'h00;
    idle_inputs();
    test_reset();
    test_latency();
    test_bit_order(8'b1000_0001, exp81_a, exp81_a, "bit_order");
    test_bit_order(8'hA5, expa5, expa5, "pattern_a5");
    test_window_blank();
    test_blink(1'b1);
    test_blink(1'b0);
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_pixel_out.md
Name: vga_pixel_out

Overview:
- Output stage of the 128x128 monochrome bitmap VGA path.
- Consumes the byte read from the character/bitmap ROM and the registered bit index from the upstream address stage (rom_addr = y*16 + x/8, index = x[2:0], 1-cycle registered).
- Serialises the selected bit to RGB, delay-aligns hsync/vsync/window to the ROM pipeline, and applies optional per-frame blinking.
- Drives the VGA pins directly.

Parameters:
- ROM_LAT, 1, ROM read latency in cycles from rom_addr to rom_data (legal 1..4).
- FG_COLOR, 3'b010, RGB for a set pixel inside the window.
- BG_COLOR, 3'b000, RGB for a clear pixel inside the window.
- BLINK_FRAMES, 30, frames per blink half-period (legal 1..255).

Ports:
- clk  input  1  pixel clock.
- rst  input  1  synchronous, active-high reset.
- in_hsync  input  1  active-low hsync, aligned with the x/y presented to the address stage (cycle t).
- in_vsync  input  1  active-low vsync, cycle t.
- in_window  input  1  1 when x/y at cycle t lie inside the 128x128 bitmap and the display is active.
- index  input  3  bit index from the address stage, valid at t+1.
- rom_data  input  8  ROM byte, valid at t+1+ROM_LAT.
- blink_en  input  1  1 = blank set pixels during the blink-off phase.
- out_hsync  output  1  delayed hsync to the pin.
- out_vsync  output  1  delayed vsync to the pin.
- out_rgb  output  3  {R,G,B} to the pin.
- frame_tick  output  1  one-cycle pulse per frame start.

Behaviour:
- Single clock domain. Reset is synchronous and active-high and overrides everything on the same edge.
- Reset values:
  - out_hsync = 1, out_vsync = 1, out_rgb = 0, frame_tick = 0.
  - All delay-line stages: hsync = 1, vsync = 1, window = 0.
  - Index delay stages = 0, blink counter = 0, blink_phase = 0, vsync_prev = 0.
- Alignment:
  - index is delayed ROM_LAT cycles, producing idx_d aligned with rom_data.
  - hsync/vsync/window are delayed ROM_LAT+1 cycles, aligned with rom_data.
  - The final output register adds 1 cycle, so pins reflect cycle-t inputs at t+ROM_LAT+2 (default: 3 cycles).
- Pixel select:
  - pix = rom_data[7 - idx_d]; bit 7 is the leftmost pixel of the byte.
  - Only the lower 3 bits of the subtraction are used; no other width growth.
- Colour, registered:
  - window_d=0 -> out_rgb = 3'b000. This is blanking and is forced regardless of rom_data.
  - window_d=1 and pix=1 and !(blink_en && blink_phase) -> FG_COLOR.
  - Otherwise BG_COLOR.
- Frame detection:
  - Falling edge of in_vsync (vsync_prev=1, in_vsync=0), using the undelayed input.
  - frame_tick is registered, high exactly 1 cycle following the edge.
  - vsync_prev resets to 0, so no tick occurs on the first cycle after reset even if in_vsync is low.
- Blink counter:
  - 8-bit, advances on each frame edge.
  - When it equals BLINK_FRAMES-1 on an edge, it wraps to 0 and blink_phase toggles.
  - blink_phase therefore changes only at frame boundaries; it keeps counting while blink_en=0.
  - blink_en is sampled every cycle (no frame gating); a change takes effect on the next output pixel.
- Reset mid-frame: pins return to reset values on the next edge. The pipeline refills with blank/inactive values, so no stale pixels appear after reset; the first valid pixel is ROM_LAT+2 cycles after the first in_window=1.
- No backpressure and no handshake: one pixel per clock, continuously.

Test Plan:
- Latency: ROM_LAT=1; pulse in_hsync low for 1 cycle at t=10 -> out_hsync low exactly at t=13 and high at t=12 and t=14. Same check for in_vsync and in_window.
- Bit order: rom_data=8'b1000_0001 held, index stepping 0..7 with window=1 -> out_rgb sequence FG,BG,BG,BG,BG,BG,BG,FG (010,000,...,010).
- Window blanking: rom_data=8'hFF, in_window=0 -> out_rgb=000 on every cycle. Repeat with BG_COLOR=3'b001: still 000 outside the window and 001 is never seen.
- Blink: BLINK_FRAMES=2, blink_en=1, rom_data=8'hFF, window=1; generate 4 vsync falling edges ->
  - frame_tick pulses 4 times, 1 cycle each.
  - blink_phase toggles after edges 2 and 4.
  - out_rgb = 000 during frames 3–4 and 010 otherwise.
  - With blink_en=0, out_rgb is 010 throughout.
- Reset: assert rst for 1 cycle mid-line with window=1 and pixels active -> next edge gives out_rgb=000, out_hsync=1, out_vsync=1, frame_tick=0. Hold in_vsync=0 across the reset release -> no frame_tick.
- ROM_LAT=3: sync/window latency is 5 cycles; bit pattern 8'hA5 with index 0..7 -> FG,BG,FG,BG,BG,FG,BG,FG, aligned to the delayed window.
